bbpd_vote_decimator: RTL and testbench

- Upstream of the CDR digital loop filter.
- Takes one data sample and one edge sample per UI and forms Alexander bang-bang early/late votes.
- Sums the votes over a fixed window of valid UIs.
- Emits a single-cycle up or dn pulse per window, which the loop filter consumes directly on clk.

---
 rtl/bbpd_pkg.sv | 7 +
 rtl/bbpd_alexander_vote.sv | 11 +
 rtl/bbpd_vote_decimator.sv | 83 ++++++++
 tb/tb_bbpd_vote_decimator.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bbpd_pkg.sv
// bbpd_pkg: shared vote type and vote-to-integer conversion for the bang-bang phase detector
package bbpd_pkg;
  typedef enum logic [1:0] {VOTE_NONE, VOTE_EARLY, VOTE_LATE} vote_t;
  function automatic logic signed [1:0] vote_to_int(input vote_t v);
    return v == VOTE_LATE ? 2'sd1 : v == VOTE_EARLY ? -2'sd1 : 2'sd0;
  endfunction
endpackage

// File: rtl/bbpd_alexander_vote.sv
// bbpd_alexander_vote: combinational Alexander early/late vote; in prev_data,data_in,edge_in; out vote
module bbpd_alexander_vote
  import bbpd_pkg::*;
(
  input  logic  prev_data,
  input  logic  data_in,
  input  logic  edge_in,
  output vote_t vote
);
  always_comb vote = prev_data == data_in ? VOTE_NONE : edge_in == data_in ? VOTE_LATE : VOTE_EARLY;
endmodule

// File: rtl/bbpd_vote_decimator.sv
// bbpd_vote_decimator: sums bang-bang votes over 2**LOG2_WIN valid UIs, pulses up/dn/dec_strobe a cycle after each window; ports clk,rst,in_valid,data_in,edge_in -> up,dn,dec_strobe[,lock when BBPD_LOCK_DET_EN]
module bbpd_vote_decimator
  import bbpd_pkg::*;
#(
  parameter int LOG2_WIN  = 4,
  parameter int THRESH    = 2,
  parameter int LOCK_TH   = 1,
  parameter int LOCK_WINS = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  input  logic data_in,
  input  logic edge_in,
  output logic up,
  output logic dn,
  output logic dec_strobe
`ifdef BBPD_LOCK_DET_EN
  ,
  output logic lock
`endif
);
  localparam int AW = LOG2_WIN + 2;
  localparam logic signed [AW-1:0] TH = AW'(THRESH);
  logic [LOG2_WIN-1:0] cnt;
  logic signed [AW-1:0] acc, vote_w, sum;
  logic prev_data, prev_valid, done;
  vote_t v;
  bbpd_alexander_vote u_vote (
    .prev_data(prev_data),
    .data_in  (data_in),
    .edge_in  (edge_in),
    .vote     (v)
  );
  always_comb begin
    vote_w = prev_valid ? AW'(vote_to_int(v)) : '0;
    sum    = acc + vote_w;
    done   = in_valid & (&cnt);
  end
`ifdef BBPD_LOCK_DET_EN
  localparam int LW = $clog2(LOCK_WINS + 1);
  logic [LW-1:0] lcnt, lcnt_nxt;
  logic [AW-1:0] mag;
  always_comb begin
    mag      = sum[AW-1] ? -sum : sum;
    lcnt_nxt = mag > AW'(LOCK_TH) ? '0 : lcnt == LW'(LOCK_WINS) ? lcnt : lcnt + 1'b1;
  end
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      up         <= 1'b0;
      dn         <= 1'b0;
      dec_strobe <= 1'b0;
      acc        <= '0;
      cnt        <= '0;
      prev_data  <= 1'b0;
      prev_valid <= 1'b0;
`ifdef BBPD_LOCK_DET_EN
      lcnt       <= '0;
      lock       <= 1'b0;
`endif
    end else begin
      up         <= 1'b0;
      dn         <= 1'b0;
      dec_strobe <= 1'b0;
      if (in_valid) begin
        prev_data  <= data_in;
        prev_valid <= 1'b1;
        cnt        <= cnt + 1'b1;
        acc        <= done ? '0 : sum;
        if (done) begin
          dec_strobe <= 1'b1;
          up         <= sum > TH;
          dn         <= sum < -TH;
`ifdef BBPD_LOCK_DET_EN
          lcnt       <= lcnt_nxt;
          lock       <= lcnt_nxt == LW'(LOCK_WINS);
`endif
        end
      end
    end
  end
endmodule

// File: tb/tb_bbpd_vote_decimator.sv
// tb_bbpd_vote_decimator: directed self-checking bench for bbpd_vote_decimator
module tb_bbpd_vote_decimator;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic data_in = 1'b0;
  logic edge_in = 1'b0;
  logic up, dn, dec_strobe;
`ifdef BBPD_LOCK_DET_EN
  logic lock;
`endif
  int total = 0;
  int bad = 0;
  int n_up = 0, n_dn = 0, n_st = 0, n_both = 0;
  always #5 clk = ~clk;
  bbpd_vote_decimator dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .data_in   (data_in),
    .edge_in   (edge_in),
    .up        (up),
    .dn        (dn),
    .dec_strobe(dec_strobe)
`ifdef BBPD_LOCK_DET_EN
    ,
    .lock      (lock)
`endif
  );
  always @(negedge clk) begin
    if (up) n_up++;
    if (dn) n_dn++;
    if (dec_strobe) n_st++;
    if (up && dn) n_both++;
  end
  task automatic ui(input logic d, input logic e);
    in_valid = 1'b1;
    data_in  = d;
    edge_in  = e;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic do_reset;
    rst = 1'b1;
    in_valid = 1'b0;
    idle(2);
    rst = 1'b0;
  endtask
  task automatic test_reset;
    do_reset;
    total++;
    if ({up, dn, dec_strobe} !== 3'b000) begin
      bad++;
      $display("FAIL reset_outputs got=%b want=000", {up, dn, dec_strobe});
    end
`ifdef BBPD_LOCK_DET_EN
    total++;
    if (lock !== 1'b0) begin
      bad++;
      $display("FAIL reset_lock got=%b want=0", lock);
    end
`endif
  endtask
  task automatic test_late;
    int u0, d0;
    logic d;
    do_reset;
    u0 = n_up;
    d0 = n_dn;
    d = 1'b0;
    for (int i = 0; i < 16; i++) begin
      ui(d, d);
      d = ~d;
      if (i == 14) begin
        total++;
        if (dec_strobe !== 1'b0) begin
          bad++;
          $display("FAIL late_early_strobe got=%b want=0", dec_strobe);
        end
      end
    end
    total++;
    if ({dec_strobe, up, dn} !== 3'b110) begin
      bad++;
      $display("FAIL late_win1 got=%b want=110", {dec_strobe, up, dn});
    end
    idle(1);
    total++;
    if ({dec_strobe, up, dn} !== 3'b000) begin
      bad++;
      $display("FAIL late_pulse_width got=%b want=000", {dec_strobe, up, dn});
    end
    for (int i = 0; i < 16; i++) begin
      ui(d, d);
      d = ~d;
    end
    total++;
    if ({dec_strobe, up, dn} !== 3'b110) begin
      bad++;
      $display("FAIL late_win2 got=%b want=110", {dec_strobe, up, dn});
    end
    idle(1);
    total++;
    if (n_up - u0 !== 2 || n_dn - d0 !== 0) begin
      bad++;
      $display("FAIL late_counts got up=%0d dn=%0d want up=2 dn=0", n_up - u0, n_dn - d0);
    end
  endtask
  task automatic test_early;
    int u0, d0, s0;
    logic p, d;
    do_reset;
    u0 = n_up;
    d0 = n_dn;
    s0 = n_st;
    ui(1'b0, 1'b0);
    p = 1'b0;
    for (int i = 0; i < 31; i++) begin
      d = ~p;
      ui(d, p);
      p = d;
      if (i == 14) begin
        total++;
        if ({dec_strobe, up, dn} !== 3'b101) begin
          bad++;
          $display("FAIL early_win1 got=%b want=101", {dec_strobe, up, dn});
        end
      end
    end
    total++;
    if ({dec_strobe, up, dn} !== 3'b101) begin
      bad++;
      $display("FAIL early_win2 got=%b want=101", {dec_strobe, up, dn});
    end
    idle(1);
    total++;
    if (n_up - u0 !== 0 || n_dn - d0 !== 2 || n_st - s0 !== 2) begin
      bad++;
      $display("FAIL early_counts got up=%0d dn=%0d st=%0d want 0 2 2", n_up - u0, n_dn - d0, n_st - s0);
    end
  endtask
  task automatic test_threshold;
    logic [15:0] w2, w3, we;
    logic p;
    w2 = 16'b0000_0000_0000_0010;
    w3 = 16'b1111_1111_1111_1101;
    we = 16'b0000_0000_0000_0010;
    do_reset;
    for (int i = 0; i < 16; i++) ui(w2[i], w2[i]);
    total++;
    if ({dec_strobe, up, dn} !== 3'b100) begin
      bad++;
      $display("FAIL thresh_plus2 got=%b want=100", {dec_strobe, up, dn});
    end
    for (int i = 0; i < 16; i++) ui(w3[i], w3[i]);
    total++;
    if ({dec_strobe, up, dn} !== 3'b110) begin
      bad++;
      $display("FAIL thresh_plus3 got=%b want=110", {dec_strobe, up, dn});
    end
    p = 1'b1;
    for (int i = 0; i < 16; i++) begin
      ui(we[i], p);
      p = we[i];
    end
    total++;
    if ({dec_strobe, up, dn} !== 3'b101) begin
      bad++;
      $display("FAIL thresh_minus3 got=%b want=101", {dec_strobe, up, dn});
    end
    p = 1'b0;
    for (int i = 0; i < 16; i++) begin
      ui(w2[i], p);
      p = w2[i];
    end
    total++;
    if ({dec_strobe, up, dn} !== 3'b100) begin
      bad++;
      $display("FAIL thresh_minus2 got=%b want=100", {dec_strobe, up, dn});
    end
  endtask
  task automatic test_gaps;
    int s0;
    logic d;
    do_reset;
    s0 = n_st;
    d = 1'b0;
    for (int i = 0; i < 16; i++) begin
      ui(d, d);
      d = ~d;
      if (i < 15) begin
        idle(2);
      end
    end
    total++;
    if ({dec_strobe, up, dn} !== 3'b110) begin
      bad++;
      $display("FAIL gaps_pulse got=%b want=110", {dec_strobe, up, dn});
    end
    total++;
    if (n_st - s0 !== 0) begin
      bad++;
      $display("FAIL gaps_early_strobe got=%0d want=0", n_st - s0);
    end
    idle(1);
  endtask
  task automatic test_mid_reset;
    int u0, d0, s0;
    logic d, p;
    do_reset;
    d = 1'b0;
    for (int i = 0; i < 10; i++) begin
      ui(d, d);
      d = ~d;
    end
    do_reset;
    u0 = n_up;
    d0 = n_dn;
    s0 = n_st;
    p = 1'b0;
    for (int i = 0; i < 16; i++) begin
      d = ~p;
      ui(d, i % 2 == 1 ? d : p);
      p = d;
      if (i == 14) begin
        total++;
        if (n_st - s0 !== 0 || dec_strobe !== 1'b0) begin
          bad++;
          $display("FAIL midrst_early_strobe got=%0d/%b want=0/0", n_st - s0, dec_strobe);
        end
      end
    end
    total++;
    if ({dec_strobe, up, dn} !== 3'b100) begin
      bad++;
      $display("FAIL midrst_window got=%b want=100", {dec_strobe, up, dn});
    end
    idle(1);
    total++;
    if (n_up - u0 !== 0 || n_dn - d0 !== 0 || n_both !== 0) begin
      bad++;
      $display("FAIL midrst_counts got up=%0d dn=%0d both=%0d want 0 0 0", n_up - u0, n_dn - d0, n_both);
    end
  endtask
`ifdef BBPD_LOCK_DET_EN
  task automatic test_lock;
    logic d, p;
    do_reset;
    p = 1'b0;
    for (int w = 0; w < 8; w++) begin
      for (int i = 0; i < 16; i++) begin
        d = ~p;
        ui(d, i % 2 == 1 ? d : p);
        p = d;
      end
      if (w == 6) begin
        total++;
        if ({dec_strobe, lock} !== 2'b10) begin
          bad++;
          $display("FAIL lock_win7 got=%b want=10", {dec_strobe, lock});
        end
      end
    end
    total++;
    if ({dec_strobe, lock} !== 2'b11) begin
      bad++;
      $display("FAIL lock_win8 got=%b want=11", {dec_strobe, lock});
    end
    for (int i = 0; i < 16; i++) begin
      d = ~p;
      ui(d, d);
      p = d;
    end
    total++;
    if ({dec_strobe, up, lock} !== 3'b110) begin
      bad++;
      $display("FAIL lock_win9 got=%b want=110", {dec_strobe, up, lock});
    end
  endtask
`endif
  initial begin
    test_reset;
    test_late;
    test_early;
    test_threshold;
    test_gaps;
    test_mid_reset;
`ifdef BBPD_LOCK_DET_EN
    test_lock;
`endif
    total++;
    if (n_both !== 0) begin
      bad++;
      $display("FAIL up_dn_overlap got=%0d want=0", n_both);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
